// File: rtl/frame_update_scheduler.sv
// Frame-locked scheduler: turns DTG vertical sync into a divided KCPSM6 interrupt and
// commits the firmware's double-buffered game_info byte only on that scheduling tick.
module frame_update_scheduler #(
   parameter logic [3:0]  PORT_GAME_INFO = 4'h0,
   parameter logic [3:0]  PORT_CTRL      = 4'h1,
   parameter int unsigned FRAME_DIV      = 1
) (
   input  logic       clock,
   input  logic       rst,
   input  logic       vert_sync,
   input  logic [3:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       interrupt_ack,
   output logic       interrupt,
   output logic [7:0] game_info_reg,
   output logic [7:0] frame_count,
   output logic       overrun
);

   typedef enum logic [1:0] {StIdle, StAssert, StRearm} state_e;

   localparam logic [7:0] DivLast = 8'(FRAME_DIV - 1);

   state_e     state_q, state_d;
   logic       vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;
   logic [7:0] div_cnt_q, div_cnt_d;
   logic [7:0] shadow_q, game_info_q, frame_count_q;
   logic       pending_q, enable_q, overrun_q, interrupt_q;
   logic       wr_game, wr_ctrl, sched_tick, set_overrun;
   logic       unused_ctrl_bits;

   assign wr_game    = write_strobe && (port_id == PORT_GAME_INFO);
   assign wr_ctrl    = write_strobe && (port_id == PORT_CTRL);
   assign sched_tick = frame_tick_q && enable_q && (div_cnt_q == DivLast);

   assign unused_ctrl_bits = ^out_port[6:1];

   // Sync flops reset high (vsync idle level) so reset never fakes a frame start.
   always_ff @(posedge clock) begin
      if (rst) begin
         vs_meta_q    <= 1'b1;
         vs_sync_q    <= 1'b1;
         vs_prev_q    <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         vs_meta_q    <= vert_sync;
         vs_sync_q    <= vs_meta_q;
         vs_prev_q    <= vs_sync_q;
         frame_tick_q <= vs_prev_q & ~vs_sync_q;
      end
   end

   always_comb begin
      div_cnt_d = div_cnt_q;
      if (!enable_q) begin
         div_cnt_d = 8'd0;
      end else if (frame_tick_q) begin
         div_cnt_d = (div_cnt_q == DivLast) ? 8'd0 : div_cnt_q + 8'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      set_overrun = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (sched_tick) state_d = StAssert;
         end
         StAssert: begin
            if (interrupt_ack && sched_tick) begin
               state_d = StRearm;
            end else if (interrupt_ack) begin
               state_d = StIdle;
            end else if (sched_tick) begin
               set_overrun = 1'b1;
            end
         end
         StRearm: begin
            state_d     = StAssert;
            set_overrun = sched_tick;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q       <= StIdle;
         interrupt_q   <= 1'b0;
         div_cnt_q     <= 8'd0;
         shadow_q      <= 8'd0;
         pending_q     <= 1'b0;
         game_info_q   <= 8'd0;
         frame_count_q <= 8'd0;
         enable_q      <= 1'b1;
         overrun_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         interrupt_q <= (state_d == StAssert);
         div_cnt_q   <= div_cnt_d;
         if (frame_tick_q) frame_count_q <= frame_count_q + 8'd1;
         // Commit the old shadow first; a same-cycle write re-arms pending for the next tick.
         if (sched_tick && pending_q) begin
            game_info_q <= shadow_q;
            pending_q   <= 1'b0;
         end
         if (wr_game) begin
            shadow_q  <= out_port;
            pending_q <= 1'b1;
         end
         if (wr_ctrl) enable_q <= out_port[7];
         // A new overrun event beats a simultaneous firmware clear.
         if (set_overrun) begin
            overrun_q <= 1'b1;
         end else if (wr_ctrl && out_port[0]) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign interrupt     = interrupt_q;
   assign game_info_reg = game_info_q;
   assign frame_count   = frame_count_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: one instance with FRAME_DIV=1 and one with
// FRAME_DIV=3 share stimulus; expected values go through a scoreboard queue.
module tb_frame_update_scheduler;

   logic       clock = 1'b0;
   logic       rst, vert_sync, write_strobe, interrupt_ack;
   logic [3:0] port_id;
   logic [7:0] out_port;
   logic       int1, ovr1, int3, ovr3;
   logic [7:0] gi1, fc1, gi3, fc3;

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run = 0;
   int   tests_failed = 0;
   int   fcount = 0;

   always #5 clock = ~clock;

   frame_update_scheduler #(.FRAME_DIV(1)) dut1 (
      .clock(clock), .rst(rst), .vert_sync(vert_sync), .port_id(port_id),
      .out_port(out_port), .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
      .interrupt(int1), .game_info_reg(gi1), .frame_count(fc1), .overrun(ovr1)
   );

   frame_update_scheduler #(.FRAME_DIV(3)) dut3 (
      .clock(clock), .rst(rst), .vert_sync(vert_sync), .port_id(port_id),
      .out_port(out_port), .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
      .interrupt(int3), .game_info_reg(gi3), .frame_count(fc3), .overrun(ovr3)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input string tag, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [7:0] obs);
      exp_t e;
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic wr(input logic [3:0] p, input logic [7:0] d);
      port_id      = p;
      out_port     = d;
      write_strobe = 1'b1;
      tick();
      write_strobe = 1'b0;
      port_id      = 4'hf;
   endtask

   task automatic ack();
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
   endtask

   // Leaves the bench in the cycle where frame_tick/sched_tick is high (edge+3).
   task automatic frame_pre();
      repeat (3) tick();
      vert_sync = 1'b0;
      fcount++;
      repeat (3) tick();
   endtask

   task automatic frame_post();
      tick();
      vert_sync = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst    = 1'b0;
      fcount = 0;
   endtask

   initial begin
      rst = 1'b1; vert_sync = 1'b1; write_strobe = 1'b0; interrupt_ack = 1'b0;
      port_id = 4'hf; out_port = 8'h00;
      do_reset();

      push("rst_int", 8'h00);  check({7'd0, int1});
      push("rst_gi", 8'h00);   check(gi1);
      push("rst_fc", 8'h00);   check(fc1);
      push("rst_ovr", 8'h00);  check({7'd0, ovr1});
      push("rst_int3", 8'h00); check({7'd0, int3});

      // First commit and its 4-clock latency.
      wr(4'h0, 8'h5A);
      frame_pre();
      push("lat_gi_early", 8'h00);  check(gi1);
      push("lat_int_early", 8'h00); check({7'd0, int1});
      frame_post();
      push("lat_gi", 8'h5A);  check(gi1);
      push("lat_int", 8'h01); check({7'd0, int1});
      push("lat_fc", 8'h01);  check(fc1);
      ack();
      push("ack_idle", 8'h00); check({7'd0, int1});

      // Reset mid-ASSERT with overrun set and data pending.
      wr(4'h0, 8'h33);
      frame_pre(); frame_post();
      push("t1_gi", 8'h33); check(gi1);
      frame_pre(); frame_post();
      push("t1_ovr_pre", 8'h01); check({7'd0, ovr1});
      wr(4'h0, 8'h44);
      rst = 1'b1;
      tick();
      push("t1_rst_int", 8'h00); check({7'd0, int1});
      push("t1_rst_gi", 8'h00);  check(gi1);
      push("t1_rst_ovr", 8'h00); check({7'd0, ovr1});
      push("t1_rst_fc", 8'h00);  check(fc1);
      tick();
      rst    = 1'b0;
      fcount = 0;
      frame_pre(); frame_post();
      push("t1_post_int", 8'h01); check({7'd0, int1});
      push("t1_post_gi", 8'h00);  check(gi1);
      ack();

      // Divide-by-3 instance: interrupts after frames 3 and 6 only.
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         push($sformatf("div3_int_f%0d", i), (i % 3 == 0) ? 8'h01 : 8'h00);
         frame_pre(); frame_post();
         check({7'd0, int3});
         ack();
      end
      push("div3_fc", 8'(fcount)); check(fc3);
      push("div3_ovr", 8'h00);     check({7'd0, ovr3});

      // Unserviced tick sets overrun; clear keeps enable at 1.
      frame_pre(); frame_post();
      push("t4_int", 8'h01); check({7'd0, int1});
      frame_pre(); frame_post();
      push("t4_ovr", 8'h01);     check({7'd0, ovr1});
      push("t4_int_hold", 8'h01); check({7'd0, int1});
      wr(4'h1, 8'h81);
      push("t4_clr", 8'h00); check({7'd0, ovr1});
      frame_pre(); frame_post();
      push("t4_enable_kept", 8'h01); check({7'd0, ovr1});
      ack();
      push("t4_ack", 8'h00); check({7'd0, int1});
      wr(4'h1, 8'h81);

      // Disabled divider: no tick, frame counter still runs.
      wr(4'h1, 8'h00);
      frame_pre(); frame_post();
      push("dis_int", 8'h00);      check({7'd0, int1});
      push("dis_fc", 8'(fcount));  check(fc1);
      wr(4'h1, 8'h80);

      // Ack coincident with sched_tick -> one-cycle REARM gap.
      frame_pre(); frame_post();
      frame_pre();
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
      vert_sync     = 1'b1;
      push("t5_gap", 8'h00);     check({7'd0, int1});
      push("t5_gap_ovr", 8'h00); check({7'd0, ovr1});
      tick();
      push("t5_rearm", 8'h01);    check({7'd0, int1});
      push("t5_rearm_ovr", 8'h00); check({7'd0, ovr1});
      ack();

      // Write on the sched_tick cycle: old shadow commits, new byte waits.
      wr(4'h0, 8'h11);
      frame_pre();
      wr(4'h0, 8'h22);
      vert_sync = 1'b1;
      push("t6_old", 8'h11); check(gi1);
      ack();
      frame_pre(); frame_post();
      push("t6_new", 8'h22); check(gi1);
      ack();
      wr(4'h2, 8'h99);
      frame_pre(); frame_post();
      push("t6_hold", 8'h22); check(gi1);
      ack();

      if (exp_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $error("FAIL scoreboard_leftover: observed %0d entries required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
